// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and sequencing helper for the intersection controller.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Green phases sit on even codes, yellow phases on odd codes.
  typedef enum logic [2:0] {
    NS_FWD_G  = 3'd0,
    NS_FWD_Y  = 3'd1,
    NS_LEFT_G = 3'd2,
    NS_LEFT_Y = 3'd3,
    EW_FWD_G  = 3'd4,
    EW_FWD_Y  = 3'd5,
    EW_LEFT_G = 3'd6,
    EW_LEFT_Y = 3'd7
  } phase_e;

  function automatic phase_e next_phase(input phase_e p);
    logic [2:0] w_code;
    w_code = p + 3'd1;
    return phase_e'(w_code);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for the current phase; flags the last cycle of the phase.
module phase_timer #(
  parameter int CW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [CW:0] i_duration,
  output logic        o_expire
);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_last;

  assign w_last   = i_duration - 1'b1;
  assign o_expire = ({1'b0, r_count} == w_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_controller.sv
// Fixed-time four-way controller: phase register, per-phase duration select and Moore lamp decode.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] N_forward,
  output logic [1:0] N_left,
  output logic [1:0] S_forward,
  output logic [1:0] S_left,
  output logic [1:0] E_forward,
  output logic [1:0] E_left,
  output logic [1:0] W_forward,
  output logic [1:0] W_left
);

  localparam int MAXT = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int DW   = CW + 1;

  phase_e        r_phase;
  logic [DW-1:0] w_duration;
  logic          w_expire;

  assign w_duration = r_phase[0] ? DW'(YELLOW_TIME) : DW'(GREEN_TIME);

  phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_duration (w_duration),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= NS_FWD_G;
    end else if (w_expire) begin
      r_phase <= next_phase(r_phase);
    end
  end

  always_comb begin
    N_forward = RED;
    N_left    = RED;
    S_forward = RED;
    S_left    = RED;
    E_forward = RED;
    E_left    = RED;
    W_forward = RED;
    W_left    = RED;
    case (r_phase)
      NS_FWD_G:  begin N_forward = GREEN;  S_forward = GREEN;  end
      NS_FWD_Y:  begin N_forward = YELLOW; S_forward = YELLOW; end
      NS_LEFT_G: begin N_left    = GREEN;  S_left    = GREEN;  end
      NS_LEFT_Y: begin N_left    = YELLOW; S_left    = YELLOW; end
      EW_FWD_G:  begin E_forward = GREEN;  W_forward = GREEN;  end
      EW_FWD_Y:  begin E_forward = YELLOW; W_forward = YELLOW; end
      EW_LEFT_G: begin E_left    = GREEN;  W_left    = GREEN;  end
      EW_LEFT_Y: begin E_left    = YELLOW; W_left    = YELLOW; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench: default-timing controller plus a 1/1-timing instance sharing clock and reset.
module tb_traffic_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic [1:0] nf, nl, sf, sl, ef, el, wf, wl;
  logic [1:0] q_nf, q_nl, q_sf, q_sl, q_ef, q_el, q_wf, q_wl;

  traffic_controller dut (
    .clk(clk), .reset(reset),
    .N_forward(nf), .N_left(nl), .S_forward(sf), .S_left(sl),
    .E_forward(ef), .E_left(el), .W_forward(wf), .W_left(wl)
  );

  traffic_controller #(.GREEN_TIME(1), .YELLOW_TIME(1)) dut1 (
    .clk(clk), .reset(reset),
    .N_forward(q_nf), .N_left(q_nl), .S_forward(q_sf), .S_left(q_sl),
    .E_forward(q_ef), .E_left(q_el), .W_forward(q_wf), .W_left(q_wl)
  );

  // Packed as {N_f, S_f, N_l, S_l, E_f, W_f, E_l, W_l}.
  wire [15:0] lamps  = {nf, sf, nl, sl, ef, wf, el, wl};
  wire [15:0] lamps1 = {q_nf, q_sf, q_nl, q_sl, q_ef, q_wf, q_el, q_wl};

  typedef struct {
    string       name;
    int          dwell;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic inv_ok(input logic [15:0] v);
    logic [7:0] mask;
    logic       bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (v[2*i +: 2] != 2'b00);
      if (v[2*i +: 2] == 2'b11) bad = 1'b1;
    end
    return !bad && (mask == 8'b1100_0000 || mask == 8'b0011_0000 ||
                    mask == 8'b0000_1100 || mask == 8'b0000_0011);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0] = '{"NS_FWD_G",  5, 16'hA000};
    tbl[1] = '{"NS_FWD_Y",  2, 16'h5000};
    tbl[2] = '{"NS_LEFT_G", 5, 16'h0A00};
    tbl[3] = '{"NS_LEFT_Y", 2, 16'h0500};
    tbl[4] = '{"EW_FWD_G",  5, 16'h00A0};
    tbl[5] = '{"EW_FWD_Y",  2, 16'h0050};
    tbl[6] = '{"EW_LEFT_G", 5, 16'h000A};
    tbl[7] = '{"EW_LEFT_Y", 2, 16'h0005};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", lamps, 16'hA000);
    check("reset_state_1x1", lamps1, 16'hA000);
    reset = 1'b0;

    // Three full cycles from reset release; sample k sees the phase after k edges
    k = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      for (int p = 0; p < 8; p++) begin
        for (int c = 0; c < tbl[p].dwell; c++) begin
          check(tbl[p].name, lamps, tbl[p].exp);
          check("invariant", {15'd0, inv_ok(lamps)}, 16'd1);
          check("corner_1x1", lamps1, tbl[k % 8].exp);
          check("invariant_1x1", {15'd0, inv_ok(lamps1)}, 16'd1);
          $display("cycle %0d phase %s lamps %h lamps1 %h", k, tbl[p].name, lamps, lamps1);
          step();
          k++;
        end
      end
    end
    check("wrap_to_NS_FWD_G", lamps, 16'hA000);

    // Mid-phase asynchronous reset during EW_LEFT_G (2 cycles in)
    repeat (23) step();
    check("pre_midreset_EW_LEFT_G", lamps, 16'h000A);
    #2 reset = 1'b1;
    #1;
    check("midreset_immediate", lamps, 16'hA000);
    check("midreset_immediate_1x1", lamps1, 16'hA000);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("post_midreset_green", lamps, 16'hA000);
      step();
    end
    check("post_midreset_yellow0", lamps, 16'h5000);
    step();
    check("post_midreset_yellow1", lamps, 16'h5000);
    step();
    check("post_midreset_left", lamps, 16'h0A00);
    $display("mid-phase reset sequence done lamps %h", lamps);

    // Held reset for 10 cycles
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("held_reset", lamps, 16'hA000);
      check("held_reset_1x1", lamps1, 16'hA000);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("after_hold_green", lamps, 16'hA000);
      check("after_hold_1x1", lamps1, tbl[c].exp);
      step();
    end
    check("after_hold_yellow", lamps, 16'h5000);
    $display("held reset sequence done lamps %h", lamps);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
# traffic_controller

Fixed-time controller for a four-way intersection with a separate forward and protected-left signal head per approach (N, S, E, W). It cycles through eight phases, serving opposing approaches together: North/South forward, North/South left, East/West forward, then East/West left. Each served movement gets a green then a yellow interval. It is a free-running top-level block with no sensor inputs, and drives eight 2-bit lamp codes.

## Interface
Parameters:
- GREEN_TIME, 5, green interval length in clock cycles (≥1)
- YELLOW_TIME, 2, yellow interval length in clock cycles (≥1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- N_forward, N_left  output  2  north forward / left lamp code
- S_forward, S_left  output  2  south forward / left lamp code
- E_forward, E_left  output  2  east forward / left lamp code
- W_forward, W_left  output  2  west forward / left lamp code

Lamp codes: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN, 2'b11 reserved and never driven.

## Operation
- Phase register holds one of eight states, in this fixed order, then wraps to the first: NS_FWD_G, NS_FWD_Y, NS_LEFT_G, NS_LEFT_Y, EW_FWD_G, EW_FWD_Y, EW_LEFT_G, EW_LEFT_Y.
- Phase duration: GREEN_TIME cycles for *_G states, YELLOW_TIME cycles for *_Y states.
- Outputs are a Moore decode of the phase only:
  - NS_FWD_G/Y: N_forward and S_forward are GREEN/YELLOW.
  - NS_LEFT_G/Y: N_left and S_left are GREEN/YELLOW.
  - EW_FWD_G/Y: E_forward and W_forward are GREEN/YELLOW.
  - EW_LEFT_G/Y: E_left and W_left are GREEN/YELLOW.
  - Every other output is RED.
- Safety invariant: exactly two heads are non-RED in every cycle, and they are always the opposing pair of one movement. No forward and left head, and no N/S and E/W heads, are non-RED together.
- No input other than reset influences sequencing.

## Timing
- Reset asserted, at any time including mid-phase: immediately, without waiting for a clock edge, phase ← NS_FWD_G and cycle counter ← 0.
  - N_forward = S_forward = 2'b10; all six other outputs = 2'b00.
- Reset held high: state stays frozen at the reset values.
- Each rising edge with reset low:
  - If counter == duration(phase) − 1: phase ← next phase and counter ← 0.
  - Otherwise: counter ← counter + 1.
- Outputs change only on the clock edge that changes the phase. Latency from phase change to outputs is zero cycles, because the decode is combinational from the phase register. Outputs must be glitch-free between edges.
- After reset deasserts, NS_FWD_G lasts exactly GREEN_TIME rising edges. Full cycle = 4·(GREEN_TIME+YELLOW_TIME) cycles (28 with defaults).
- Duration of 1: the phase lasts a single cycle.
- Counter width: $clog2(max(GREEN_TIME, YELLOW_TIME)) bits, minimum 1. The counter never exceeds duration − 1.

## Structure
- Package traffic_pkg holds:
  - lamp-code constants RED, YELLOW, GREEN;
  - the 3-bit phase enum in the order above;
  - a next-phase function.
- One sub-module: phase_timer. It contains the counter, takes the current duration as input and pulses `expire` on the terminal count. It resets asynchronously with the parent.
- Top level contains the phase register, the duration select and the output decode.

## Test plan
- Reset, defaults: assert reset for 1 cycle, then release. Check N/S_forward = 2'b10 and all others 2'b00. Check it holds for exactly 5 edges, then N/S_forward = 2'b01 for 2 edges.
- Full sequence: over 28 cycles after reset, the phases occur in the listed order with durations 5,2,5,2,5,2,5,2. At cycle 28 the controller is back at NS_FWD_G.
- Invariant check: every cycle across 3 full cycles, exactly the opposing pair is non-RED. No output ever equals 2'b11.
- Mid-phase reset: assert reset asynchronously between edges during EW_LEFT_G. Outputs return to NS_FWD_G immediately. After release, the counter restarts and a full 5-cycle green follows.
- Held reset: keep reset high for 10 cycles. Outputs stay constant at the reset values.
- Parameter corner: GREEN_TIME=1, YELLOW_TIME=1. Every phase lasts 1 cycle and the period is 8 cycles.
